fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_if.sv | 15 +
 rtl/fetch_queue.sv | 84 ++++++++
 tb/tb_fetch_queue.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch request/completion bus between the fetch queue and the request unit
// Signals:
//   mem_req    fetch request, held until mem_ready
//   mem_addr   byte address of the outstanding fetch
//   mem_ready  one-cycle completion pulse
//   mem_rdata  read data, valid with mem_ready
// Modports: master (fetch queue side), slave (request unit side)
interface fetch_queue_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    modport master (output mem_req, mem_addr, input mem_ready, mem_rdata);
    modport slave (input mem_req, mem_addr, output mem_ready, mem_rdata);
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue with one outstanding fetch and flush redirect
// Ports:
//   clk, nrst                         clock, asynchronous active-low reset
//   flush, redirect_addr              discard queue, restart fetch at redirect_addr (word aligned)
//   consume                           core takes the head entry this cycle
//   dmem_pending                      data access owns the RAM port, hold off new fetches
//   instr_out, instr_addr, instr_valid  head entry, its byte address, queue non-empty
//   bus                               fetch request/completion (master side)
module fetch_queue #(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          flush,
    input  logic [31:0]   redirect_addr,
    input  logic          consume,
    input  logic          dmem_pending,
    output logic [31:0]   instr_out,
    output logic [31:0]   instr_addr,
    output logic          instr_valid,
    fetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
    state_t        state, state_nxt;
    logic [AW-1:0] head, tail;
    logic [CW-1:0] count;
    logic [31:0]   fetch_pc, req_addr;
    logic [31:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic          issue, wr, pop;

    assign issue       = state == IDLE && !flush && !dmem_pending && count < CW'(DEPTH);
    assign wr          = state == REQ && bus.mem_ready && !flush;
    assign pop         = consume && instr_valid && !flush;
    assign instr_valid = count != '0;
    // Gated by instr_valid so unwritten storage never reaches the outputs.
    assign instr_out   = instr_valid ? data_q[head] : '0;
    assign instr_addr  = instr_valid ? addr_q[head] : '0;
    assign bus.mem_req  = state != IDLE;
    assign bus.mem_addr = req_addr;

    // mem_ready always ends the fetch; a flush while still waiting turns it into a drop.
    always_comb begin
        state_nxt = state;
        state_nxt = state == IDLE ? (issue ? REQ : IDLE) : bus.mem_ready ? IDLE : flush ? DROP : state;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            fetch_pc <= RESET_ADDR;
            req_addr <= RESET_ADDR;
        end else begin
            state <= state_nxt;
            if (issue) req_addr <= fetch_pc;
            if (flush) begin
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                fetch_pc <= redirect_addr & ~32'h3;
            end else begin
                if (wr) begin
                    tail     <= tail + 1'b1;
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (pop) head <= head + 1'b1;
                count <= count + CW'(wr) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            addr_q[tail] <= fetch_pc;
            data_q[tail] <= bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and randomized bench for fetch_queue against a queue-based model
module tb_fetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RA    = 32'h0000_0000;

    logic        clk = 1'b0, nrst = 1'b1, flush = 1'b0, dmem_pending = 1'b0;
    logic        cons_req = 1'b0, cor = 1'b0;
    logic [31:0] redirect_addr = 32'h0;
    logic        consume;
    logic [31:0] instr_out, instr_addr;
    logic        instr_valid;
    int          checks = 0, errors = 0;
    bit          chk_en = 0, resp_en = 0, rand_lat = 0, stray_en = 0;
    int          lat = 0, wait_cnt = 0;

    fetch_queue_if bus();

    fetch_queue #(.DEPTH(DEPTH), .RESET_ADDR(RA)) dut (
        .clk(clk), .nrst(nrst), .flush(flush), .redirect_addr(redirect_addr),
        .consume(consume), .dmem_pending(dmem_pending), .instr_out(instr_out),
        .instr_addr(instr_addr), .instr_valid(instr_valid), .bus(bus)
    );

    assign consume = cons_req | (cor & bus.mem_ready);

    initial forever #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic wait_req(input logic want, input string n);
        int i = 0;
        while (bus.mem_req !== want && i < 50) begin
            @(negedge clk);
            i++;
        end
        chk(n, 32'(bus.mem_req), 32'(want));
    endtask

    task automatic wait_valid(input string n);
        int i = 0;
        while (instr_valid !== 1'b1 && i < 50) begin
            @(negedge clk);
            i++;
        end
        chk(n, 32'(instr_valid), 32'h1);
    endtask

    // Reference model: a FIFO of {addr,data}, the next fetch address, and whether a fetch is
    // in flight and whether its data is to be thrown away.
    typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;
    ent_t        q[$];
    logic [31:0] m_pc = RA, m_addr = RA;
    bit          m_busy = 0, m_drop = 0;

    initial forever begin
        @(posedge clk or negedge nrst);
        if (!nrst) begin
            q.delete();
            m_pc = RA;
            m_addr = RA;
            m_busy = 0;
            m_drop = 0;
        end else begin
            bit do_pop, do_start;
            do_pop = consume && q.size() > 0 && !flush;
            do_start = !m_busy && !flush && !dmem_pending && q.size() < DEPTH;
            if (do_pop) void'(q.pop_front());
            if (m_busy && bus.mem_ready) begin
                if (!m_drop && !flush) begin
                    q.push_back('{m_addr, bus.mem_rdata});
                    m_pc = m_addr + 32'd4;
                end
                m_busy = 0;
                m_drop = 0;
            end else if (m_busy && flush) m_drop = 1;
            if (do_start) begin
                m_busy = 1;
                m_addr = m_pc;
            end
            if (flush) begin
                q.delete();
                m_pc = {redirect_addr[31:2], 2'b00};
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("cmp_valid", 32'(instr_valid), 32'(q.size() > 0));
            chk("cmp_instr_addr", instr_addr, q.size() > 0 ? q[0].a : 32'h0);
            chk("cmp_instr_out", instr_out, q.size() > 0 ? q[0].d : 32'h0);
            chk("cmp_mem_req", 32'(bus.mem_req), 32'(m_busy));
            if (m_busy) chk("cmp_mem_addr", bus.mem_addr, m_addr);
        end
    end

    // Request unit: answers with addr^FFFFFFFF after lat cycles, garbage data otherwise.
    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            bus.mem_ready = 1'b0;
            bus.mem_rdata = $urandom;
            if (resp_en && nrst && bus.mem_req) begin
                if (wait_cnt >= lat) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = bus.mem_addr ^ 32'hFFFF_FFFF;
                    wait_cnt = 0;
                    lat = rand_lat ? int'($urandom_range(0, 3)) : 0;
                end else wait_cnt++;
            end else begin
                wait_cnt = 0;
                if (stray_en && nrst && !bus.mem_req && $urandom_range(0, 7) == 0) bus.mem_ready = 1'b1;
            end
        end
    end

    initial begin
        #2 nrst = 1'b0;
        #1;
        chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
        chk("rst_mem_addr", bus.mem_addr, RA);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_instr_out", instr_out, 32'h0);
        chk("rst_instr_addr", instr_addr, 32'h0);
        @(negedge clk);
        nrst = 1'b1;
        chk_en = 1;
        resp_en = 1;
        @(negedge clk);
        chk("first_req", 32'(bus.mem_req), 32'h1);
        chk("first_addr", bus.mem_addr, RA);
        repeat (14) @(negedge clk);
        chk("full_head_addr", instr_addr, 32'h0);
        chk("full_head_data", instr_out, 32'hFFFF_FFFF);
        repeat (3) begin
            @(negedge clk);
            chk("full_no_req", 32'(bus.mem_req), 32'h0);
        end
        cons_req = 1'b1;
        @(negedge clk);
        cons_req = 1'b0;
        chk("pop_head_addr", instr_addr, 32'h4);
        chk("pop_head_data", instr_out, ~32'h4);
        chk("pop_no_req", 32'(bus.mem_req), 32'h0);
        @(negedge clk);
        chk("refill_req", 32'(bus.mem_req), 32'h1);
        chk("refill_addr", bus.mem_addr, 32'h10);
        @(negedge clk);
        resp_en = 0;
        flush = 1'b1;
        redirect_addr = 32'h8;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_empty", 32'(instr_valid), 32'h0);
        @(negedge clk);
        chk("req8", 32'(bus.mem_req), 32'h1);
        chk("req8_addr", bus.mem_addr, 32'h8);
        flush = 1'b1;
        redirect_addr = 32'h103;
        @(negedge clk);
        flush = 1'b0;
        chk("drop_req_hold", 32'(bus.mem_req), 32'h1);
        chk("drop_addr_hold", bus.mem_addr, 32'h8);
        chk("drop_empty", 32'(instr_valid), 32'h0);
        @(negedge clk);
        resp_en = 1;
        wait_valid("redirect_fill");
        chk("redirect_addr", instr_addr, 32'h100);
        chk("redirect_data", instr_out, ~32'h100);
        dmem_pending = 1'b1;
        wait_req(1'b0, "dmem_idle");
        repeat (5) begin
            @(negedge clk);
            chk("dmem_block", 32'(bus.mem_req), 32'h0);
        end
        dmem_pending = 1'b0;
        @(negedge clk);
        chk("dmem_release", 32'(bus.mem_req), 32'h1);
        dmem_pending = 1'b1;
        flush = 1'b1;
        redirect_addr = 32'h300;
        @(negedge clk);
        flush = 1'b0;
        wait_req(1'b0, "empty_idle");
        cons_req = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("empty_consume", 32'(instr_valid), 32'h0);
        end
        cons_req = 1'b0;
        dmem_pending = 1'b0;
        repeat (4) @(negedge clk);
        chk("two_entries_head", instr_addr, 32'h300);
        cor = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("steady_valid", 32'(instr_valid), 32'h1);
        end
        dmem_pending = 1'b1;
        wait_req(1'b0, "steady_idle");
        cor = 1'b0;
        cons_req = 1'b1;
        @(negedge clk);
        chk("drain1", 32'(instr_valid), 32'h1);
        @(negedge clk);
        chk("drain2", 32'(instr_valid), 32'h0);
        cons_req = 1'b0;
        dmem_pending = 1'b0;
        resp_en = 0;
        flush = 1'b1;
        redirect_addr = 32'h20;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        chk("req20", 32'(bus.mem_req), 32'h1);
        chk("req20_addr", bus.mem_addr, 32'h20);
        #1 nrst = 1'b0;
        #1;
        chk("arst_mem_req", 32'(bus.mem_req), 32'h0);
        chk("arst_mem_addr", bus.mem_addr, RA);
        chk("arst_valid", 32'(instr_valid), 32'h0);
        chk("arst_instr_out", instr_out, 32'h0);
        chk("arst_instr_addr", instr_addr, 32'h0);
        @(negedge clk);
        #1 nrst = 1'b1;
        resp_en = 1;
        stray_en = 1;
        @(negedge clk);
        chk("restart_req", 32'(bus.mem_req), 32'h1);
        chk("restart_addr", bus.mem_addr, RA);
        rand_lat = 1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            flush = $urandom_range(0, 15) == 0;
            redirect_addr = $urandom;
            cons_req = 1'($urandom_range(0, 1));
            dmem_pending = $urandom_range(0, 3) == 0;
            if ($urandom_range(0, 399) == 0) begin
                #1 nrst = 1'b0;
                @(negedge clk);
                #1 nrst = 1'b1;
            end
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
